// File: rtl/icache_dm_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped instruction cache.
package icache_dm_pkg;

    localparam int ICDM_ADDR_W     = 32;
    localparam int ICDM_IDX_W      = 6;
    localparam int ICDM_LINE_WORDS = 4;
    localparam int ICDM_OFF_W      = 2;   // log2(ICDM_LINE_WORDS)
    localparam int ICDM_LINE_LSB   = ICDM_OFF_W + 2;  // byte bits below the index
    localparam int ICDM_TAG_W      = ICDM_ADDR_W - ICDM_LINE_LSB - ICDM_IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icdm_state_e;

    // Field slices of a fetch byte address with the default geometry.
    function automatic logic [ICDM_OFF_W-1:0] icdm_off(input logic [ICDM_ADDR_W-1:0] a);
        return a[ICDM_LINE_LSB-1:2];
    endfunction

    function automatic logic [ICDM_IDX_W-1:0] icdm_idx(input logic [ICDM_ADDR_W-1:0] a);
        return a[ICDM_LINE_LSB+ICDM_IDX_W-1:ICDM_LINE_LSB];
    endfunction

    function automatic logic [ICDM_TAG_W-1:0] icdm_tag(input logic [ICDM_ADDR_W-1:0] a);
        return a[ICDM_ADDR_W-1:ICDM_LINE_LSB+ICDM_IDX_W];
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Storage for the instruction cache: data words, tags and per-line valid bits.
// Reads are combinational; writes happen on the clock edge. Only the valid
// bits are reset, the data and tag RAMs come up undefined.
module icache_dm_array
    import icache_dm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ICDM_IDX_W-1:0]  rd_idx_i,
    input  logic [ICDM_OFF_W-1:0]  rd_off_i,
    output logic [31:0]            rd_data_o,
    output logic [ICDM_TAG_W-1:0]  rd_tag_o,
    output logic                   rd_valid_o,
    input  logic                   wr_en_i,
    input  logic [ICDM_IDX_W-1:0]  wr_idx_i,
    input  logic [ICDM_OFF_W-1:0]  wr_off_i,
    input  logic [31:0]            wr_data_i,
    input  logic                   tag_we_i,
    input  logic [ICDM_TAG_W-1:0]  tag_i,
    input  logic                   valid_set_i,
    input  logic                   valid_clr_all_i
);

    localparam int LINES = 1 << ICDM_IDX_W;

    logic [31:0]           data_q  [LINES][ICDM_LINE_WORDS];
    logic [ICDM_TAG_W-1:0] tag_q   [LINES];
    logic [LINES-1:0]      valid_q;

    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

    // Refill word and tag writes; no reset on the RAM contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= tag_i;
        end
    end

    // Valid bits: clear-all wins over a same-cycle set so a flush is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (valid_clr_all_i) begin
            valid_q <= '0;
        end else if (valid_set_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hit path, 4-word line refill
// from memory on a miss, and whole-cache invalidate via flush.
//
// Memory handshake: while mem_req=1 the cache holds mem_addr steady; a cycle
// with mem_ready=1 means mem_rdata belongs to that mem_addr and is consumed on
// that clock edge, after which mem_addr advances to the next word. mem_ready
// seen while mem_req=0 carries no meaning and is ignored.
module icache_dm
    import icache_dm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ICDM_ADDR_W-1:0] if_addr,
    output logic [31:0]            if_inst,
    output logic                   if_valid,
    output logic                   stall_req,
    input  logic                   flush,
    output logic                   mem_req,
    output logic [ICDM_ADDR_W-1:0] mem_addr,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready,
    output icdm_state_e            dbg_state_o
);

    icdm_state_e            state_q, state_d;
    logic [ICDM_OFF_W-1:0]  cnt_q, cnt_d;
    logic [ICDM_ADDR_W-1:0] base_q, base_d;
    logic [ICDM_IDX_W-1:0]  idx_q, idx_d;
    logic                   fpend_q, fpend_d;

    logic [ICDM_OFF_W-1:0]  req_off;
    logic [ICDM_IDX_W-1:0]  req_idx;
    logic [ICDM_TAG_W-1:0]  req_tag;
    logic [31:0]            rd_data;
    logic [ICDM_TAG_W-1:0]  rd_tag;
    logic                   rd_valid;
    logic                   hit;

    logic                   wr_en, tag_we, valid_set, valid_clr;
    logic [ICDM_IDX_W-1:0]  wr_idx;
    logic [ICDM_TAG_W-1:0]  wr_tag;

    logic                   inst_valid, stall, req;
    logic [31:0]            inst;
    logic [ICDM_ADDR_W-1:0] addr;

    // Byte-select bits of the fetch address are not needed for word fetches.
    logic unused_byte_bits;
    assign unused_byte_bits = ^if_addr[1:0];

    assign req_off = icdm_off(if_addr);
    assign req_idx = icdm_idx(if_addr);
    assign req_tag = icdm_tag(if_addr);

    icache_dm_array u_array (
        .clk             (clk),
        .rst             (rst),
        .rd_idx_i        (req_idx),
        .rd_off_i        (req_off),
        .rd_data_o       (rd_data),
        .rd_tag_o        (rd_tag),
        .rd_valid_o      (rd_valid),
        .wr_en_i         (wr_en),
        .wr_idx_i        (wr_idx),
        .wr_off_i        (cnt_q),
        .wr_data_i       (mem_rdata),
        .tag_we_i        (tag_we),
        .tag_i           (wr_tag),
        .valid_set_i     (valid_set),
        .valid_clr_all_i (valid_clr)
    );

    assign hit = if_req && rd_valid && (rd_tag == req_tag);

    // The stored tag is simply the upper field of the latched line base.
    assign wr_tag = icdm_tag(base_q);
    assign wr_idx = idx_q;

    // Lookup, miss detection and refill sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        idx_d      = idx_q;
        fpend_d    = fpend_q;
        inst_valid = 1'b0;
        inst       = 32'h0;
        stall      = 1'b0;
        req        = 1'b0;
        addr       = '0;
        wr_en      = 1'b0;
        tag_we     = 1'b0;
        valid_set  = 1'b0;
        valid_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Lookup this cycle still sees the pre-flush valid bits.
                valid_clr = flush;
                if (if_req) begin
                    if (hit) begin
                        inst_valid = 1'b1;
                        inst       = rd_data;
                    end else begin
                        stall   = 1'b1;
                        base_d  = {req_tag, req_idx, {ICDM_LINE_LSB{1'b0}}};
                        idx_d   = req_idx;
                        cnt_d   = '0;
                        fpend_d = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                req     = 1'b1;
                stall   = 1'b1;
                // Line base has zero low bits, so OR-ing the word offset never carries.
                addr    = base_q | {{(ICDM_ADDR_W-ICDM_LINE_LSB){1'b0}}, cnt_q, 2'b00};
                fpend_d = fpend_q | flush;
                if (mem_ready) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ICDM_OFF_W'(ICDM_LINE_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        // A flush seen at any point of the fill discards this line too.
                        if (fpend_q || flush) begin
                            valid_clr = 1'b1;
                        end else begin
                            valid_set = 1'b1;
                        end
                        fpend_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and fill bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            fpend_q <= fpend_d;
        end
    end

    // Outputs are forced quiet while reset is held, even if the core keeps requesting.
    assign if_valid    = inst_valid & ~rst;
    assign if_inst     = rst ? 32'h0 : inst;
    assign stall_req   = stall & ~rst;
    assign mem_req     = req & ~rst;
    assign mem_addr    = rst ? '0 : addr;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm: cold miss, hits, conflict eviction,
// flush (idle and mid-fill), reset mid-fill, address wrap and idle quiet.
module tb_icache_dm;
    import icache_dm_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall_req;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    icdm_state_e dbg_state;

    int vectors;
    int miscompares;

    icache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .stall_req   (stall_req),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .dbg_state_o (dbg_state)
    );

    // Clock: 10 ns period; inputs change on negedge, outputs checked 1 ns later.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a fetch in IDLE that must miss: stall at once, no memory request yet.
    task automatic start_miss(input logic [31:0] a, input string nm);
        @(negedge clk);
        if_req = 1'b1; if_addr = a; mem_ready = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (stall_req !== 1'b1 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_miss: stall=%b valid=%b mem_req=%b, need stall=1 valid=0 mem_req=0",
                     nm, stall_req, if_valid, mem_req);
        end
    endtask

    // Drive a 4-word refill: 'gap' idle cycles before each ready, optional flush on one word.
    task automatic fill_line(input logic [31:0] base, input logic [31:0] d0,
                             input int gap, input int flush_word, input string nm);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                mem_ready = 1'b0; flush = 1'b0;
                #1;
                vectors++;
                if (mem_req !== 1'b1 || stall_req !== 1'b1 || mem_addr !== base + 32'(4*w)) begin
                    miscompares++;
                    $display("FAIL %s_wait%0d: mem_req=%b stall=%b addr=%h, need 1 1 %h",
                             nm, w, mem_req, stall_req, mem_addr, base + 32'(4*w));
                end
            end
            @(negedge clk);
            mem_ready = 1'b1; mem_rdata = d0 + 32'(w); flush = (w == flush_word);
            #1;
            vectors++;
            if (mem_req !== 1'b1 || stall_req !== 1'b1 || if_valid !== 1'b0 ||
                mem_addr !== base + 32'(4*w)) begin
                miscompares++;
                $display("FAIL %s_word%0d: mem_req=%b stall=%b valid=%b addr=%h, need 1 1 0 %h",
                         nm, w, mem_req, stall_req, if_valid, mem_addr, base + 32'(4*w));
            end
        end
    endtask

    // Present a fetch that must hit with the given instruction and no memory traffic.
    task automatic expect_hit(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        if_req = 1'b1; if_addr = a; mem_ready = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b1 || if_inst !== exp || stall_req !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_hit: valid=%b inst=%h stall=%b mem_req=%b, need 1 %h 0 0",
                     nm, if_valid, if_inst, stall_req, mem_req, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (if_valid !== 1'b0 || stall_req !== 1'b0 || mem_req !== 1'b0 ||
            mem_addr !== 32'h0 || if_inst !== 32'h0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b stall=%b mem_req=%b addr=%h inst=%h st=%0d, need all 0",
                     if_valid, stall_req, mem_req, mem_addr, if_inst, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || stall_req !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b stall=%b mem_req=%b, need 0 0 0",
                     if_valid, stall_req, mem_req);
        end
    endtask

    task automatic test_cold_miss();
        start_miss(32'h100, "cold");
        fill_line(32'h100, 32'hA0, 1, -1, "cold");
        expect_hit(32'h100, 32'hA0, "cold");
    endtask

    task automatic test_hits_in_line();
        expect_hit(32'h104, 32'hA1, "line1");
        expect_hit(32'h108, 32'hA2, "line2");
        expect_hit(32'h10C, 32'hA3, "line3");
    endtask

    task automatic test_conflict();
        start_miss(32'h500, "evict");
        fill_line(32'h500, 32'hB0, 0, -1, "evict");
        expect_hit(32'h508, 32'hB2, "evict");
        start_miss(32'h100, "refetch");
        fill_line(32'h100, 32'hA0, 0, -1, "refetch");
        expect_hit(32'h100, 32'hA0, "refetch");
    endtask

    task automatic test_flush();
        // Flush cycle itself still hits on the old valid bits.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; flush = 1'b1;
        #1;
        vectors++;
        if (if_valid !== 1'b1 || if_inst !== 32'hA0) begin
            miscompares++;
            $display("FAIL flush_cycle_hit: valid=%b inst=%h, need 1 000000a0", if_valid, if_inst);
        end
        start_miss(32'h100, "post_flush");
        fill_line(32'h100, 32'hA0, 0, 1, "flush_fill");
        start_miss(32'h100, "after_flushed_fill");
        fill_line(32'h100, 32'hA0, 0, -1, "clean_fill");
        expect_hit(32'h104, 32'hA1, "clean_fill");
    endtask

    task automatic test_reset_mid_fill();
        start_miss(32'h200, "rstfill");
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hC0;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hC1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h208) begin
            miscompares++;
            $display("FAIL rstfill_pre: mem_req=%b addr=%h, need 1 00000208", mem_req, mem_addr);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0 || if_valid !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL rstfill_async: mem_req=%b stall=%b valid=%b st=%0d, need 0 0 0 IDLE",
                     mem_req, stall_req, if_valid, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (stall_req !== 1'b1 || if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstfill_remiss: stall=%b valid=%b, need 1 0", stall_req, if_valid);
        end
        fill_line(32'h200, 32'hC0, 0, -1, "rstfill");
        expect_hit(32'h20C, 32'hC3, "rstfill");
    endtask

    task automatic test_addr_wrap();
        start_miss(32'hFFFF_FFFC, "wrap");
        fill_line(32'hFFFF_FFF0, 32'hD0, 0, -1, "wrap");
        expect_hit(32'hFFFF_FFFC, 32'hD3, "wrap");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req = 1'b0; if_addr = $urandom(); flush = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (mem_req !== 1'b0 || stall_req !== 1'b0 || if_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle%0d: mem_req=%b stall=%b valid=%b, need 0 0 0",
                         i, mem_req, stall_req, if_valid);
            end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_cold_miss();
        test_hits_in_line();
        test_conflict();
        test_flush();
        test_reset_mid_fill();
        test_addr_wrap();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
